// File: rtl/shift_arbiter_if.sv
// Command/result bundle between the execute-stage issue ports and shift_arbiter.
// The arbiter takes the slave view; the issue side (or a bench) drives the master view.
interface shift_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_in;
   logic [3*NREQ-1:0]   req_mode;
   logic [4*NREQ-1:0]   req_n;
   logic                res_valid;
   logic                res_ready;
   logic [15:0]         res_data;
   logic [IDW-1:0]      res_id;

   modport master (
      output req_valid, req_in, req_mode, req_n, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
      input  req_valid, req_in, req_mode, req_n, res_ready,
      output req_ready, res_valid, res_data, res_id
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit funnel shifter among NREQ requesters, one-entry result reg.
// Define SHIFT_ARB_STATS_EN to add per-requester saturating grant counters (stat_sel/stat_count).
module shift_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
`ifdef SHIFT_ARB_STATS_EN
   input  logic [IDW-1:0] stat_sel,
   output logic [15:0]    stat_count,
`endif
   shift_arbiter_if.slave bus
);

   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  ptr_d;
   logic            res_valid_q;
   logic [15:0]     res_data_q;
   logic [IDW-1:0]  res_id_q;

   logic            slot_free;
   logic            any_valid;
   logic            transfer;
   logic [IDW-1:0]  gnt_id;
   logic [NREQ-1:0] gnt_oh;

   logic [15:0]     sh_in;
   logic [2:0]      sh_mode;
   logic [3:0]      sh_n;
   logic [4:0]      sh_inv;
   logic [15:0]     sh_out;

   // Same-cycle drain frees the slot, so back-to-back transfers run at full rate.
   assign slot_free = !res_valid_q || bus.res_ready;
   assign transfer  = slot_free && any_valid;

   // First valid requester at or after the pointer, searching upward modulo NREQ.
   always_comb begin
      int unsigned idx;
      logic [IDW-1:0] cand;
      idx       = 0;
      cand      = '0;
      any_valid = 1'b0;
      gnt_id    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         cand = IDW'(idx);
         if (!any_valid && bus.req_valid[cand]) begin
            any_valid = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   always_comb begin
      gnt_oh = '0;
      if (transfer) begin
         gnt_oh[gnt_id] = 1'b1;
      end
   end

   assign bus.req_ready = gnt_oh;

   always_comb begin
      sh_in   = '0;
      sh_mode = '0;
      sh_n    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDW'(i) == gnt_id) begin
            sh_in   = bus.req_in[16*i +: 16];
            sh_mode = bus.req_mode[3*i +: 3];
            sh_n    = bus.req_n[4*i +: 4];
         end
      end
   end

   // Complementary shift for the rotates; a shift by 16 yields zero, so n=0 rotates cleanly.
   assign sh_inv = 5'd16 - {1'b0, sh_n};

   always_comb begin
      case (sh_mode)
         3'b001:         sh_out = sh_in >> sh_n;
         3'b010:         sh_out = $signed(sh_in) >>> sh_n;
         3'b011:         sh_out = (sh_in >> sh_n) | (sh_in << sh_inv);
         3'b101, 3'b110: sh_out = sh_in << sh_n;
         3'b111:         sh_out = (sh_in << sh_n) | (sh_in >> sh_inv);
         default:        sh_out = sh_in;
      endcase
   end

   assign ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         ptr_q       <= '0;
      end else if (transfer) begin
         res_valid_q <= 1'b1;
         res_data_q  <= sh_out;
         res_id_q    <= gnt_id;
         ptr_q       <= ptr_d;
      end else if (bus.res_ready) begin
         res_valid_q <= 1'b0;
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;

`ifdef SHIFT_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (transfer && (cnt_q[gnt_id] != 16'hFFFF)) begin
         cnt_q[gnt_id] <= cnt_q[gnt_id] + 16'd1;
      end
   end

   // Selects beyond the last requester match no entry and read as zero.
   always_comb begin
      stat_count = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDW'(i) == stat_sel) begin
            stat_count = cnt_q[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: scoreboard of expected results, checked with immediate asserts.
// Stats checks compile in only when SHIFT_ARB_STATS_EN is defined.
module tb_shift_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [15:0]    data;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shift_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef SHIFT_ARB_STATS_EN
   logic [IDW-1:0] stat_sel;
   logic [15:0]    stat_count;
`endif

   shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef SHIFT_ARB_STATS_EN
      .stat_sel   (stat_sel),
      .stat_count (stat_count),
`endif
      .bus        (bus)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   res_t        sbq[$];
   bit          pend = 1'b0;
   res_t        last;
   logic [15:0] op_in   [NREQ];
   logic [2:0]  op_mode [NREQ];
   logic [3:0]  op_n    [NREQ];
   logic [15:0] lit     [8];

   // Bit-by-bit reference shifter.
   function automatic logic [15:0] model(input logic [15:0] x, input logic [2:0] m,
                                         input logic [3:0] n);
      logic [15:0] r;
      int s;
      r = x;
      s = int'(n);
      for (int k = 0; k < 16; k++) begin
         case (m)
            3'b001:         r[k] = (k + s < 16) ? x[k + s] : 1'b0;
            3'b010:         r[k] = (k + s < 16) ? x[k + s] : x[15];
            3'b011:         r[k] = x[(k + s) % 16];
            3'b101, 3'b110: r[k] = (k - s >= 0) ? x[k - s] : 1'b0;
            3'b111:         r[k] = x[(k - s + 16) % 16];
            default:        r[k] = x[k];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int unsigned i, input logic [15:0] v, input logic [2:0] m,
                          input logic [3:0] n);
      op_in[i]   = v;
      op_mode[i] = m;
      op_n[i]    = n;
      bus.req_in[16*i +: 16] = v;
      bus.req_mode[3*i +: 3] = m;
      bus.req_n[4*i +: 4]    = n;
   endtask

   task automatic rand_ops();
      for (int unsigned i = 0; i < NREQ; i++) begin
         set_req(i, 16'($urandom), 3'($urandom), 4'($urandom));
      end
   endtask

   // One cycle: pop/compare last cycle's result (or check it is held), check grant, push.
   task automatic tick(input logic [NREQ-1:0] exp_rdy, input bit hold);
      res_t e;
      @(negedge clk);
      if (pend) begin
         e = sbq.pop_front();
         chk("res_valid", 32'(bus.res_valid), 32'd1);
         chk("res_data", 32'(bus.res_data), 32'(e.data));
         chk("res_id", 32'(bus.res_id), 32'(e.id));
         last = e;
         pend = 1'b0;
      end else if (hold) begin
         chk("hold_valid", 32'(bus.res_valid), 32'd1);
         chk("hold_data", 32'(bus.res_data), 32'(last.data));
         chk("hold_id", 32'(bus.res_id), 32'(last.id));
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (exp_rdy[i] && bus.req_valid[i]) begin
            e.id   = IDW'(i);
            e.data = model(op_in[i], op_mode[i], op_n[i]);
            sbq.push_back(e);
            pend = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_data", 32'(bus.res_data), 32'd0);
      chk("rst_id", 32'(bus.res_id), 32'd0);
      sbq.delete();
      pend  = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      lit = '{16'hF00F, 16'h0F00, 16'hFF00, 16'hFF00, 16'hF00F, 16'h00F0, 16'h00F0, 16'h00FF};
      bus.req_valid = '0;
      bus.req_in    = '0;
      bus.req_mode  = '0;
      bus.req_n     = '0;
      bus.res_ready = 1'b1;
      for (int unsigned i = 0; i < NREQ; i++) set_req(i, 16'h0, 3'b000, 4'h0);
`ifdef SHIFT_ARB_STATS_EN
      stat_sel = '0;
`endif

      // Reset held two cycles, nothing requesting.
      do_reset(2);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);

      // Single request from requester 1: rotate right by one.
      set_req(1, 16'h8001, 3'b011, 4'd1);
      bus.req_valid = 4'b0010;
      tick(4'b0010, 1'b0);
      bus.req_valid = '0;
      chk("single_data", 32'(bus.res_data), 32'h0000C000);
      tick(4'b0000, 1'b0);
      chk("drain_valid", 32'(bus.res_valid), 32'd0);
      chk("drain_stale", 32'(bus.res_data), 32'h0000C000);

      // Mode sweep on requester 0 (pointer sits at 2, so the search wraps).
      bus.req_valid = 4'b0001;
      for (int m = 0; m < 8; m++) begin
         set_req(0, 16'hF00F, 3'(m), 4'd4);
         if (m > 0) chk("sweep_lit", 32'(bus.res_data), 32'(lit[m-1]));
         tick(4'b0001, 1'b0);
      end
      chk("sweep_lit", 32'(bus.res_data), 32'(lit[7]));
      bus.req_valid = '0;
      tick(4'b0000, 1'b0);
      chk("sweep_drain", 32'(bus.res_valid), 32'd0);

      // Round robin from a fresh pointer, operands changing every cycle.
      do_reset(1);
      bus.req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         rand_ops();
         tick(4'(1 << (k % 4)), 1'b0);
      end

      // Backpressure: five stalled cycles, then the next grant goes to requester 2.
      bus.res_ready = 1'b0;
      rand_ops();
      tick(4'b0000, 1'b0);
      repeat (4) begin
         rand_ops();
         tick(4'b0000, 1'b1);
      end
      bus.res_ready = 1'b1;
      rand_ops();
      tick(4'b0100, 1'b1);
      bus.res_ready = 1'b0;
      tick(4'b0000, 1'b0);

      // Reset while a result is held under backpressure.
      chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_mid_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_mid_data", 32'(bus.res_data), 32'd0);
      chk("rst_mid_id", 32'(bus.res_id), 32'd0);
      sbq.delete();
      pend          = 1'b0;
      rst_n         = 1'b1;
      bus.res_ready = 1'b1;
      rand_ops();
      tick(4'b0001, 1'b0);
      rand_ops();
      tick(4'b0010, 1'b0);
      bus.req_valid = '0;
      tick(4'b0000, 1'b0);

`ifdef SHIFT_ARB_STATS_EN
      // Grant counters: three grants to requester 2, then saturation.
      do_reset(1);
      stat_sel = 2'd2;
      set_req(2, 16'h1234, 3'b101, 4'd3);
      bus.req_valid = 4'b0100;
      repeat (3) tick(4'b0100, 1'b0);
      bus.req_valid = '0;
      tick(4'b0000, 1'b0);
      chk("stat_three", 32'(stat_count), 32'd3);
      stat_sel = 2'd0;
      #1;
      chk("stat_other", 32'(stat_count), 32'd0);
      stat_sel = 2'd2;
      bus.req_valid = 4'b0100;
      repeat (65540) @(posedge clk);
      #1;
      bus.req_valid = '0;
      sbq.delete();
      pend = 1'b0;
      chk("stat_sat", 32'(stat_count), 32'h0000FFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit funnel shifter (modes nop / logical / arithmetic / rotate, left and right, amount 0-15) among NREQ requesters.
- Each requester presents an independent valid/ready shift command.
- The block arbitrates round-robin, drives the single shifter instance combinationally from the granted command, and captures the result in a one-entry output register with a valid/ready result channel tagged by requester ID.
- Sits between the execute-stage issue ports and the shared shifter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the result ID; must equal max(1, ceil(log2(NREQ))).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester command accepted; one-hot or zero.
- req_in  input  16*NREQ  operand; requester i uses bits [16*i+15:16*i].
- req_mode  input  3*NREQ  shift mode; requester i uses bits [3*i+2:3*i].
- req_n  input  4*NREQ  shift amount; requester i uses bits [4*i+3:4*i].
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  16  shifted value.
- res_id  output  IDW  index of the requester that issued the result.

Behaviour:
- Reset (rst_n low at a clock edge):
  - res_valid=0, res_data=0, res_id=0.
  - Round-robin pointer=0.
  - req_ready is combinational and therefore 0 while res_valid=0 and no req_valid is high.
  - Reset mid-transfer drops any held result; no partial state survives.
- Slot free: slot_free = !res_valid || res_ready (same-cycle drain permitted, giving full throughput).
- Grant:
  - When slot_free and any req_valid is high, grant the first valid requester at or after the pointer, searching upward modulo NREQ.
  - req_ready[g]=1 for the granted requester only. All other req_ready bits are 0.
  - When !slot_free, all req_ready bits are 0.
- Transfer: a command transfers on a cycle where req_valid[i] && req_ready[i].
- Shifter connection:
  - The shifter is instantiated once inside this block.
  - Its inputs are muxed from the granted requester's in/mode/n.
  - Its output is registered on transfer: res_data<=shift result, res_id<=g, res_valid<=1.
- Latency: exactly 1 cycle from command transfer to res_valid.
- Pointer: on transfer, pointer<=(g+1) mod NREQ. With no transfer, the pointer holds.
- Result drain: if res_valid && res_ready and there is no new transfer, res_valid<=0. res_data and res_id hold their stale values.
- Stall: res_valid && !res_ready holds res_data and res_id stable and grants nothing.
- Simultaneous drain and accept: the register is overwritten with the new result and res_valid stays 1.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,..,NREQ-1,0,… with no gaps. A lone requester is granted every cycle.
- Mode semantics:
  - 000/100 pass through unchanged.
  - 001 logical right.
  - 010 arithmetic right.
  - 011 rotate right.
  - 101 logical left.
  - 110 arithmetic left, identical to logical left.
  - 111 rotate left.
  - All by req_n bits.
- Command operands need not be stable while not granted; only the transfer-cycle values matter.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- Defined:
  - Adds ports stat_sel (input, IDW) and stat_count (output, 16).
  - One 16-bit saturating grant counter per requester, incremented on each transfer from that requester.
  - Counters saturate at 16'hFFFF and clear to 0 on reset.
  - stat_count = counter[stat_sel], combinational.
  - stat_sel >= NREQ returns 0.
- Undefined: the ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset then single request:
  - Stimulus: rst_n low 2 cycles; then req 1 valid, in=16'h8001, mode=011, n=1.
  - Response: req_ready=4'b0010 the same cycle; next cycle res_valid=1, res_data=16'hC000, res_id=1.
- Mode sweep, in=16'hF00F and n=4:
  - 001 -> 16'h0F00.
  - 010 -> 16'hFF00.
  - 101 -> 16'h00F0.
  - 111 -> 16'h00FF.
  - 000 -> 16'hF00F.
- Round robin:
  - Stimulus: all 4 requesters valid continuously, res_ready=1.
  - Response: res_id sequence 0,1,2,3,0,1 on consecutive cycles; res_valid never drops.
- Backpressure:
  - Stimulus: res_ready=0 while result present, requesters valid.
  - Response: all req_ready=0 and res_data held for 5 cycles. The cycle res_ready returns 1, the next grant issues and the new result appears one cycle later.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while res_valid=1 and res_ready=0.
  - Response: next cycle res_valid=0; the pointer restarts at requester 0.
- Stats (SHIFT_ARB_STATS_EN):
  - Stimulus: 3 grants to requester 2; stat_sel=2.
  - Response: stat_count=3. After 70000 grants the counter reads 16'hFFFF.
